instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  Fetch stage of the MIPS pipeline. Owns the PC and drives the InstructionMemory address.
//  Captures the returned word into the IF/ID pipeline register for decode.
//  Handles stall, flush and branch/jump redirect, and halts cleanly when the PC runs past the loaded program.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  IMEM_WORDS  128            number of valid instruction words; word index >= IMEM_WORDS is out of range
//  NOP_WORD    32'h0000_0000  bubble instruction (sll $0,$0,0)
// PORTS
//  Clk             in   1   clock, all state updates on rising edge
//  Rst             in   1   asynchronous, active-high reset
//  Stall           in   1   hazard unit: hold PC and IF/ID contents
//  Flush           in   1   load bubble into IF/ID next edge
//  Redirect        in   1   take RedirectTarget as next PC (branch/jump resolved)
//  RedirectTarget  in   32  byte address of redirect destination
//  Address         out  32  to InstructionMemory Address; equals PC (combinational from PC reg)
//  Instruction     in   32  from InstructionMemory; combinational read of Address
//  IFID_Instr      out  32  registered instruction to decode
//  IFID_PCPlus4    out  32  registered PC+4 of IFID_Instr
//  IFID_Valid      out  1   1 = IFID_Instr is a real fetch, 0 = bubble
//  Halted          out  1   fetch stopped; PC out of range
//  MisalignErr     out  1   sticky; a redirect target had bits[1:0] != 0
//  FetchCount      out  32  count of instructions delivered with IFID_Valid=1
// BEHAVIOUR
//  Reset (async, Rst=1): PC=RESET_PC, IFID_Instr=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0.
//   Also Halted=0, MisalignErr=0, FetchCount=0, state=RUN. Reset takes effect immediately mid-cycle.
//  Latency: word at PC appears on IFID_* one edge after PC is presented. Throughput is 1 instr/clk in RUN.
//  FSM states: RUN, HALT.
//   RUN->HALT at an edge where next-PC word index (PC[31:2]) >= IMEM_WORDS and no Redirect.
//   HALT->RUN on Redirect to an in-range target.
//   A Redirect to an out-of-range target from HALT stays in HALT (PC is still updated).
//  Next-PC priority, evaluated each edge: Redirect > Stall > HALT > PC+4.
//   Redirect: PC={RedirectTarget[31:2],2'b00}. If RedirectTarget[1:0]!=0, set MisalignErr (cleared only by Rst).
//   Stall (no Redirect): PC holds.
//   HALT (no Redirect): PC holds.
//   Otherwise: PC=PC+4, modulo 2^32 wrap with no flag.
//  IF/ID priority: Flush or Redirect > Stall > normal.
//   Flush or Redirect: IFID_Instr=NOP_WORD, IFID_Valid=0. The wrong-path word is squashed.
//   Stall: all IF/ID outputs hold.
//   Normal in RUN with in-range PC: IFID_Instr=Instruction, IFID_PCPlus4=PC+4, IFID_Valid=1.
//   Normal in HALT or with out-of-range PC: IFID_Instr=NOP_WORD, IFID_Valid=0.
//   Out-of-range memory contents are never forwarded.
//  Stall and Flush together: Flush wins for IF/ID, PC holds.
//  Stall and Redirect together: Redirect wins for both PC and IF/ID.
//  FetchCount increments by 1 exactly on edges where IFID_Valid is loaded with 1. It wraps at 2^32.
//  Halted = (state==HALT), a registered output.
// STRUCTURE
//  Shared package (fetch_pkg): NOP_WORD, RESET_PC default, RUN/HALT state encoding, PC_INCR=4.
//  One sub-module, ifid_pipe_reg: async-reset register with hold and bubble-load inputs.
//   Fields: Instr, PCPlus4, Valid.
//  PC register, FSM, misalign flag and counter stay in the top module.
// TESTING
//  1. Reset, then 5 free-running clocks with memory[i]=i*4:
//     IFID_Instr = 0,4,8,12,16; IFID_PCPlus4 = 4..20; FetchCount=5.
//  2. Stall=1 for 3 cycles at PC=0x10:
//     PC stays 0x10, IF/ID holds word 3, FetchCount frozen.
//     Release Stall -> word 4 appears next edge.
//  3. Redirect=1, RedirectTarget=0x40 while Stall=1:
//     next edge PC=0x40 and IFID_Valid=0. The edge after, IFID_Instr=memory[16], IFID_PCPlus4=0x44.
//  4. IMEM_WORDS=8, free run from 0:
//     after word 7 delivered, Halted=1, IFID_Valid=0, PC=0x20 holds.
//     Redirect to 0x0 -> Halted=0, fetch resumes at word 0.
//  5. RedirectTarget=0x13 -> PC=0x10, MisalignErr=1 and stays 1.
//     Assert Rst mid-cycle (between edges) -> all outputs take reset values immediately, MisalignErr=0.
//  6. Flush=1 and Stall=1 together at PC=0x8:
//     IFID_Valid=0, PC stays 0x8, FetchCount unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared constants, fetch state encoding and PC range helper
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam logic [31:0] c_NOP_WORD = 32'h0000_0000;
   localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] c_PC_INCR  = 32'd4;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   // True when the word index of pc addresses loaded program memory.
   function automatic logic pc_in_range(input logic [31:0] pc, input logic [31:0] words);
      return ({2'b00, pc[31:2]} < words);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_pipe_reg.sv
// ============================================================================
// Module : ifid_pipe_reg
// Brief  : IF/ID pipeline register with hold and bubble-load controls
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifid_pipe_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = c_NOP_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_hold,
   input  logic        i_bubble,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pcplus4,
   input  logic        i_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pcplus4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pcplus4;
   logic        r_valid;

   // Bubble outranks hold so a squash is never lost to a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr   <= NOP_WORD;
         r_pcplus4 <= 32'h0000_0000;
         r_valid   <= 1'b0;
      end else if (i_bubble) begin
         r_instr   <= NOP_WORD;
         r_pcplus4 <= i_pcplus4;
         r_valid   <= 1'b0;
      end else if (!i_hold) begin
         r_instr   <= i_instr;
         r_pcplus4 <= i_pcplus4;
         r_valid   <= i_valid;
      end
   end

   assign o_instr   = r_instr;
   assign o_pcplus4 = r_pcplus4;
   assign o_valid   = r_valid;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module : instruction_fetch_stage
// Brief  : MIPS fetch stage: PC, RUN/HALT FSM, IF/ID register, fetch counter
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = c_RESET_PC,
   parameter int unsigned IMEM_WORDS = 128,
   parameter logic [31:0] NOP_WORD   = c_NOP_WORD
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   output logic [31:0] Address,
   input  logic [31:0] Instruction,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid,
   output logic        Halted,
   output logic        MisalignErr,
   output logic [31:0] FetchCount
);

   localparam logic [31:0] c_WORDS = 32'(IMEM_WORDS);

   fetch_state_t r_state;
   fetch_state_t w_state_next;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_next;
   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_target;
   logic [31:0]  r_fetch_count;
   logic         r_misalign;
   logic         w_fetch_ok;
   logic         w_bubble;
   logic         w_load_valid;

   assign w_pc_plus4   = r_pc + c_PC_INCR;
   assign w_target     = {RedirectTarget[31:2], 2'b00};
   assign w_fetch_ok   = (r_state == ST_RUN) && pc_in_range(r_pc, c_WORDS);
   assign w_bubble     = Flush || Redirect;
   assign w_load_valid = !w_bubble && !Stall && w_fetch_ok;

   always_comb begin
      w_pc_next    = w_pc_plus4;
      w_state_next = r_state;
      if (Redirect) begin
         w_pc_next = w_target;
         if (r_state == ST_HALT) begin
            w_state_next = pc_in_range(w_target, c_WORDS) ? ST_RUN : ST_HALT;
         end
      end else begin
         if (Stall || (r_state == ST_HALT)) begin
            w_pc_next = r_pc;
         end
         // Stop as soon as the PC would leave the program.
         if (!pc_in_range(w_pc_next, c_WORDS)) begin
            w_state_next = ST_HALT;
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_pc          <= RESET_PC;
         r_state       <= ST_RUN;
         r_misalign    <= 1'b0;
         r_fetch_count <= 32'h0000_0000;
      end else begin
         r_pc    <= w_pc_next;
         r_state <= w_state_next;
         if (Redirect && (RedirectTarget[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
         end
         if (w_load_valid) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   ifid_pipe_reg #(
      .NOP_WORD (NOP_WORD)
   ) u_ifid (
      .clk       (Clk),
      .rst       (Rst),
      .i_hold    (Stall),
      .i_bubble  (w_bubble),
      .i_instr   (w_fetch_ok ? Instruction : NOP_WORD),
      .i_pcplus4 (w_pc_plus4),
      .i_valid   (w_fetch_ok),
      .o_instr   (IFID_Instr),
      .o_pcplus4 (IFID_PCPlus4),
      .o_valid   (IFID_Valid)
   );

   assign Address     = r_pc;
   assign Halted      = (r_state == ST_HALT);
   assign MisalignErr = r_misalign;
   assign FetchCount  = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module : tb_instruction_fetch_stage
// Brief  : Directed table plus corner sequences for the fetch stage
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

   logic        Clk;
   logic        Rst;
   logic        Stall;
   logic        Flush;
   logic        Redirect;
   logic [31:0] RedirectTarget;

   logic [31:0] a0, i0, p0, c0;
   logic        v0, h0, m0;
   logic [31:0] a8, i8, p8, c8;
   logic        v8, h8, m8;

   int checks = 0;
   int errors = 0;

   // memory[i] = i*4, i.e. the word read equals its byte address
   instruction_fetch_stage #(.IMEM_WORDS(128)) dut (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .Redirect(Redirect),
      .RedirectTarget(RedirectTarget), .Address(a0), .Instruction(a0),
      .IFID_Instr(i0), .IFID_PCPlus4(p0), .IFID_Valid(v0), .Halted(h0),
      .MisalignErr(m0), .FetchCount(c0)
   );

   instruction_fetch_stage #(.IMEM_WORDS(8)) dut8 (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .Redirect(Redirect),
      .RedirectTarget(RedirectTarget), .Address(a8), .Instruction(a8),
      .IFID_Instr(i8), .IFID_PCPlus4(p8), .IFID_Valid(v8), .Halted(h8),
      .MisalignErr(m8), .FetchCount(c8)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      logic        stall;
      logic        flush;
      logic        redir;
      logic [31:0] tgt;
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_valid;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic f, input logic r, input logic [31:0] t);
      Stall          = s;
      Flush          = f;
      Redirect       = r;
      RedirectTarget = t;
      @(posedge Clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " addr"},   a0, 32'h0);
      check({tag, " instr"},  i0, 32'h0);
      check({tag, " pc4"},    p0, 32'h0);
      check({tag, " valid"},  32'(v0), 32'h0);
      check({tag, " halted"}, 32'(h0), 32'h0);
      check({tag, " mis"},    32'(m0), 32'h0);
      check({tag, " count"},  c0, 32'h0);
   endtask

   initial begin
      //        stall flush redir tgt     addr    instr   pc4     v  cnt
      tbl[0]  = '{0, 0, 0, 32'h00, 32'h04, 32'h00, 32'h04, 1, 1};
      tbl[1]  = '{0, 0, 0, 32'h00, 32'h08, 32'h04, 32'h08, 1, 2};
      tbl[2]  = '{0, 0, 0, 32'h00, 32'h0C, 32'h08, 32'h0C, 1, 3};
      tbl[3]  = '{0, 0, 0, 32'h00, 32'h10, 32'h0C, 32'h10, 1, 4};
      tbl[4]  = '{0, 0, 0, 32'h00, 32'h14, 32'h10, 32'h14, 1, 5};
      tbl[5]  = '{0, 0, 1, 32'h0C, 32'h0C, 32'h00, 32'h00, 0, 5};
      tbl[6]  = '{0, 0, 0, 32'h00, 32'h10, 32'h0C, 32'h10, 1, 6};
      tbl[7]  = '{1, 0, 0, 32'h00, 32'h10, 32'h0C, 32'h10, 1, 6};
      tbl[8]  = '{1, 0, 0, 32'h00, 32'h10, 32'h0C, 32'h10, 1, 6};
      tbl[9]  = '{1, 0, 0, 32'h00, 32'h10, 32'h0C, 32'h10, 1, 6};
      tbl[10] = '{0, 0, 0, 32'h00, 32'h14, 32'h10, 32'h14, 1, 7};
      tbl[11] = '{1, 0, 1, 32'h40, 32'h40, 32'h00, 32'h00, 0, 7};
      tbl[12] = '{0, 0, 0, 32'h00, 32'h44, 32'h40, 32'h44, 1, 8};
      tbl[13] = '{0, 0, 1, 32'h08, 32'h08, 32'h00, 32'h00, 0, 8};
      tbl[14] = '{1, 1, 0, 32'h00, 32'h08, 32'h00, 32'h00, 0, 8};
      tbl[15] = '{0, 0, 0, 32'h00, 32'h0C, 32'h08, 32'h0C, 1, 9};
      tbl[16] = '{0, 1, 0, 32'h00, 32'h10, 32'h00, 32'h00, 0, 9};
      tbl[17] = '{0, 0, 0, 32'h00, 32'h14, 32'h10, 32'h14, 1, 10};

      Rst = 1'b1;
      Stall = 1'b0;
      Flush = 1'b0;
      Redirect = 1'b0;
      RedirectTarget = 32'h0;
      #12;
      Rst = 1'b0;
      check_reset("reset");

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].tgt);
         check($sformatf("row%0d addr", i),  a0, tbl[i].e_addr);
         check($sformatf("row%0d instr", i), i0, tbl[i].e_instr);
         check($sformatf("row%0d valid", i), 32'(v0), 32'(tbl[i].e_valid));
         check($sformatf("row%0d count", i), c0, tbl[i].e_cnt);
         check($sformatf("row%0d halted", i), 32'(h0), 32'h0);
         if (tbl[i].e_valid) begin
            check($sformatf("row%0d pc4", i), p0, tbl[i].e_pc4);
         end
      end

      // Misaligned redirect: word-aligned PC, sticky error flag
      step(0, 0, 1, 32'h13);
      check("mis addr",  a0, 32'h10);
      check("mis flag",  32'(m0), 32'h1);
      check("mis valid", 32'(v0), 32'h0);
      step(0, 0, 0, 32'h0);
      check("mis sticky", 32'(m0), 32'h1);
      check("mis instr",  i0, 32'h10);
      check("mis pc4",    p0, 32'h14);

      // Reset asserted between edges must act immediately
      #2;
      Rst = 1'b1;
      #1;
      check_reset("midrst");
      #1;
      Rst = 1'b0;

      // Small program: halt past word 7, then resume by redirect
      for (int k = 0; k < 8; k++) begin
         if (k == 7) check("h8 before", 32'(h8), 32'h0);
         step(0, 0, 0, 32'h0);
         check($sformatf("p8 instr%0d", k), i8, 32'(k * 4));
         check($sformatf("p8 valid%0d", k), 32'(v8), 32'h1);
      end
      check("p8 halted", 32'(h8), 32'h1);
      check("p8 addr",   a8, 32'h20);
      check("p8 pc4",    p8, 32'h20);
      check("p8 count",  c8, 32'd8);
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 0, 32'h0);
         check($sformatf("halt valid%0d", k),  32'(v8), 32'h0);
         check($sformatf("halt instr%0d", k),  i8, 32'h0);
         check($sformatf("halt addr%0d", k),   a8, 32'h20);
         check($sformatf("halt halted%0d", k), 32'(h8), 32'h1);
         check($sformatf("halt count%0d", k),  c8, 32'd8);
      end
      step(0, 0, 1, 32'h40);
      check("oor addr",   a8, 32'h40);
      check("oor halted", 32'(h8), 32'h1);
      check("oor valid",  32'(v8), 32'h0);
      step(0, 0, 0, 32'h0);
      check("oor hold",   a8, 32'h40);
      check("oor still",  32'(h8), 32'h1);
      step(0, 0, 1, 32'h0);
      check("resume addr",   a8, 32'h0);
      check("resume halted", 32'(h8), 32'h0);
      check("resume valid",  32'(v8), 32'h0);
      step(0, 0, 0, 32'h0);
      check("resume instr", i8, 32'h0);
      check("resume pc4",   p8, 32'h4);
      check("resume v",     32'(v8), 32'h1);
      check("resume count", c8, 32'd9);
      check("resume next",  a8, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
